life_grid_engine: RTL
=====================

LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning grid rows (>=3).
REQ-002 SHALL have parameter COLS, default 8, meaning grid columns (>=3).
REQ-003 SHALL have parameter WRAP, default 0, meaning 0 = cells beyond edges are dead, 1 = toroidal wrap-around.
REQ-004 SHALL have parameter GEN_W, default 16, meaning generation counter width.
REQ-005 SHALL have port clk, input, 1, meaning single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have port load, input, 1, meaning copy init_grid into the grid.
REQ-008 SHALL have port init_grid, input, ROWS*COLS, meaning initial pattern; cell (r,c) is at bit r*COLS+c.
REQ-009 SHALL have port run, input, 1, meaning level; free-run enable.
REQ-010 SHALL have port step, input, 1, meaning single-generation request while not running.
REQ-011 SHALL have port tick, input, 1, meaning generation-rate strobe used in RUN.
REQ-012 SHALL have port grid_out, output, ROWS*COLS, meaning current registered generation.
REQ-013 SHALL have port gen_count, output, GEN_W, meaning generations since load.
REQ-014 SHALL have port busy, output, 1, meaning FSM in RUN.
REQ-015 SHALL have port stable, output, 1, meaning last update left the grid unchanged.
REQ-016 SHALL have port extinct, output, 1, meaning the grid is all dead.

Function
REQ-017 SHALL compute the next generation combinationally from grid_out using B3/S23: a dead cell with exactly 3 live neighbours is born; a live cell with 2 or 3 live neighbours survives; every other cell is dead.
REQ-018 SHALL count 8 neighbours per cell; with WRAP=0, out-of-range neighbours count as 0; with WRAP=1, row and column indices wrap modulo ROWS/COLS.
REQ-019 SHALL register an update ("advance") so that grid_out shows the new generation on the cycle after the qualifying strobe; latency is 1 clock.
REQ-020 SHALL implement FSM states IDLE, RUN and HALT.
REQ-021 IDLE: run=1 -> RUN; step=1 with run=0 -> one advance, remain IDLE.
REQ-022 RUN: each cycle with tick=1 -> one advance; run=0 -> IDLE, and a coincident tick is ignored.
REQ-023 HALT: entered only per REQ-033; ignores run, step and tick; leaves only on load or reset.
REQ-024 load SHALL have priority over all other inputs in every state: grid <= init_grid, gen_count <= 0, stable <= 0, FSM <= IDLE.
REQ-025 Each advance SHALL increment gen_count, saturating at 2^GEN_W-1 without wrapping.
REQ-026 extinct SHALL be combinational (grid_out == 0) and valid in all states, including straight after load.
REQ-027 busy SHALL be 1 exactly when the FSM is in RUN.

Reset
REQ-028 reset=0 SHALL asynchronously clear grid_out, gen_count, stable and the FSM (to IDLE), independent of clk.
REQ-029 Assertion mid-RUN SHALL abort immediately; after deassertion, the block SHALL wait in IDLE for load, run or step.
REQ-030 Deassertion SHALL take effect at the next clk edge; no output shall change during reset.

Configuration
REQ-031 Macro LIFE_STABLE_DETECT_EN SHALL compile in stability detection and auto-halt.
REQ-032 Without LIFE_STABLE_DETECT_EN: stable is tied to 0, HALT is unreachable, and RUN continues on extinct or unchanged grids.
REQ-033 With LIFE_STABLE_DETECT_EN: stable is registered as (next == current) on each advance; if an advance in RUN yields an unchanged or all-dead grid, the FSM enters HALT on that same edge.
REQ-034 With LIFE_STABLE_DETECT_EN: a step advance in IDLE updates stable but does not enter HALT.

Structure
REQ-035 Package life_pkg SHALL hold the FSM state enum (IDLE, RUN, HALT) and the rule constants BIRTH_CNT=3, SURVIVE_MIN=2, SURVIVE_MAX=3.
REQ-036 SHALL use one sub-module, life_cell, instantiated ROWS*COLS times via generate: inputs are the current state and 8 neighbour bits, output is the next state; it contains no storage.
REQ-037 All state SHALL reside in life_grid_engine; no per-cell clocks.

Verification
REQ-038 Blinker: 8x8, load cells (3,2),(3,3),(3,4), run=1, tick every cycle -> after 1 tick (2,3),(3,3),(4,3); after 2 ticks original; gen_count=2.
REQ-039 Still life with macro: load a 2x2 block at (0,0), run -> stable=1, FSM in HALT after 1 advance, gen_count=1, busy=0.
REQ-040 Extinction with macro: a single live cell -> grid_out=0, extinct=1, HALT, gen_count=1; without macro, gen_count keeps incrementing on each tick.
REQ-041 Wrap: WRAP=1, 8x8 glider -> after 32 generations grid_out equals the loaded pattern; WRAP=0, the same run never restores it.
REQ-042 Control priority: load asserted with run and tick in RUN -> grid=init_grid, gen_count=0, IDLE; step in IDLE -> exactly one advance.
REQ-043 Saturation and reset: GEN_W=4, run 20 ticks -> gen_count holds 15; reset=0 mid-RUN -> outputs cleared before the next clk edge.

Source files
------------

// File: rtl/life_pkg.sv
// +----------------------------------------------------------------------+
// | life_pkg : FSM state type and B3/S23 rule constants for life engine   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package life_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [3:0] BIRTH_CNT   = 4'd3;
   localparam logic [3:0] SURVIVE_MIN = 4'd2;
   localparam logic [3:0] SURVIVE_MAX = 4'd3;

endpackage

`default_nettype wire

// File: rtl/life_cell.sv
// +----------------------------------------------------------------------+
// | life_cell : purely combinational next-state rule for one cell         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module life_cell
   import life_pkg::*;
(
   input  logic       alive,
   input  logic [7:0] nbrs,
   output logic       next_alive
);

   logic [3:0] cnt;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, nbrs[i]};
      end
   end

   assign next_alive = alive ? ((cnt >= SURVIVE_MIN) && (cnt <= SURVIVE_MAX))
                             : (cnt == BIRTH_CNT);

endmodule

`default_nettype wire

// File: rtl/life_grid_engine.sv
// +----------------------------------------------------------------------+
// | life_grid_engine : Conway B3/S23 grid with IDLE/RUN/HALT control.     |
// | Optional macro LIFE_STABLE_DETECT_EN adds stable flag and auto-halt.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module life_grid_engine
   import life_pkg::*;
#(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int WRAP  = 0,
   parameter int GEN_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [ROWS*COLS-1:0]   init_grid,
   input  logic                   run,
   input  logic                   step,
   input  logic                   tick,
   output logic [ROWS*COLS-1:0]   grid_out,
   output logic [GEN_W-1:0]       gen_count,
   output logic                   busy,
   output logic                   stable,
   output logic                   extinct
);

   localparam int               N       = ROWS * COLS;
   localparam logic [GEN_W-1:0] GEN_MAX = '1;

   state_t         state;
   logic [N-1:0]   next_grid;
   logic           advance;
   logic           halt_now;

   genvar r, c, k;
   generate
      for (r = 0; r < ROWS; r++) begin : g_row
         for (c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nbrs;
            for (k = 0; k < 9; k++) begin : g_nb
               if (k != 4) begin : g_use
                  localparam int RR  = r + (k / 3) - 1;
                  localparam int CC  = c + (k % 3) - 1;
                  localparam int WR  = (RR + ROWS) % ROWS;
                  localparam int WC  = (CC + COLS) % COLS;
                  localparam int NI  = (k < 4) ? k : k - 1;
                  localparam bit INR = (RR >= 0) && (RR < ROWS) &&
                                       (CC >= 0) && (CC < COLS);
                  if ((WRAP != 0) || INR) begin : g_live
                     assign nbrs[NI] = grid_out[WR*COLS + WC];
                  end else begin : g_edge
                     assign nbrs[NI] = 1'b0;
                  end
               end
            end
            life_cell u_cell (
               .alive      (grid_out[r*COLS + c]),
               .nbrs       (nbrs),
               .next_alive (next_grid[r*COLS + c])
            );
         end
      end
   endgenerate

   // A step is only honoured while idle and not simultaneously starting a run.
   always_comb begin
      advance = 1'b0;
      case (state)
         IDLE:    advance = !run && step;
         RUN:     advance = run && tick;
         default: advance = 1'b0;
      endcase
   end

`ifdef LIFE_STABLE_DETECT_EN
   logic same;
   logic stable_q;

   assign same     = (next_grid == grid_out);
   assign halt_now = same || (next_grid == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_q <= 1'b0;
      end else if (load) begin
         stable_q <= 1'b0;
      end else if (advance) begin
         stable_q <= same;
      end
   end

   assign stable = stable_q;
`else
   assign halt_now = 1'b0;
   assign stable   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         grid_out  <= '0;
         gen_count <= '0;
      end else if (load) begin
         state     <= IDLE;
         grid_out  <= init_grid;
         gen_count <= '0;
      end else begin
         if (advance) begin
            grid_out <= next_grid;
            if (gen_count != GEN_MAX) begin
               gen_count <= gen_count + GEN_W'(1);
            end
         end
         case (state)
            IDLE: begin
               if (run) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!run) begin
                  state <= IDLE;
               end else if (advance && halt_now) begin
                  state <= HALT;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = (state == RUN);
   assign extinct = (grid_out == '0);

endmodule

`default_nettype wire
